apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 122 ++++++++++++
 tb/tb_apb_master_bridge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Host-command to APB master bridge: one outstanding transfer, SETUP/ACCESS
// sequencing, wait-state counting with optional timeout abort, held response.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: cmd is taken on an edge where cmd_valid && cmd_ready; the
  // response is held until an edge where rsp_valid && rsp_ready.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam int unsigned CW    = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam int unsigned TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic          pwrite_q, pwrite_d, err_q, err_d, tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          rdata_d = pwrite_q ? 32'h0 : prdata;
          err_d   = pslverr;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // This cycle is the TIMEOUT-th wait without pready: give up.
          if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !presetn;
  assign psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable     = (state_q == S_ACCESS);
  assign rsp_valid   = (state_q == S_RESP);
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, random transfers against
// a response-level model, and hand-written reset corner sequences.
module tb_apb_master_bridge;

  localparam int unsigned TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [31:0] prdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [1:0]  dbg_state;

  apb_master_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // expected response: {timeout, err, rdata[31:0], access_cycles[7:0]}
  logic [41:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          waits;
    bit          err;
    int          hold;
    logic [41:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response-level reference: a slave that stalls `waits` cycles either
  // answers in waits+1 ACCESS cycles or is cut off after TIMEOUT cycles.
  function automatic logic [41:0] model(input bit wr, input logic [31:0] rd,
                                        input int waits, input bit err);
    if (TIMEOUT != 0 && waits >= int'(TIMEOUT))
      return {1'b1, 1'b1, 32'h0, 8'(TIMEOUT)};
    return {1'b0, err, (wr ? 32'h0 : rd), 8'(waits + 1)};
  endfunction

  // driver: one complete transfer, APB slave behaviour, response checks
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int waits, input bit err,
                         input int hold);
    logic [41:0] e;
    int cyc, psel_n, pen_n, acc;
    bit got;
    e = exp_q.pop_front();
    psel_n = 0; pen_n = 0; acc = 0; got = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge pclk); #1;
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom;
    for (cyc = 0; cyc < 100; cyc++) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (psel) begin
        psel_n++;
        chk("paddr_hold", paddr, addr);
        chk("pwrite_hold", pwrite, wr);
        chk("pwdata_hold", pwdata, wdata);
      end
      if (psel && penable) begin
        pen_n++;
        pready  = (acc == waits);
        pslverr = (acc == waits) ? err : 1'($urandom);
        prdata  = (acc == waits) ? rd : $urandom;
        acc++;
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
      @(posedge pclk); #1;
    end
    chk("rsp_seen", got, 1);
    chk("rsp_latency", cyc, e[7:0] + 1);
    chk("psel_cycles", psel_n, e[7:0] + 1);
    chk("penable_cycles", pen_n, e[7:0]);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid_hold", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, e[39:8]);
      chk("rsp_err", rsp_err, e[40]);
      chk("rsp_timeout", rsp_timeout, e[41]);
      chk("cmd_ready_resp", cmd_ready, 0);
      chk("psel_resp", {psel, penable}, 0);
      rsp_ready = (h == hold);
      cmd_valid = (h == hold) ? 1'b0 : 1'($urandom);
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("paddr_retained", paddr, addr);
    chk("psel_idle", {psel, penable}, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h1,   32'hDEADBEEF, 32'h12345678, 0,  1'b0, 0, {1'b0, 1'b0, 32'h0, 8'd1}};
    tbl[1] = '{1'b0, 32'h200, 32'h0,        32'hCAFE0001, 3,  1'b0, 1, {1'b0, 1'b0, 32'hCAFE0001, 8'd4}};
    tbl[2] = '{1'b0, 32'h500, 32'h0,        32'hAAAA5555, 0,  1'b1, 0, {1'b0, 1'b1, 32'hAAAA5555, 8'd1}};
    tbl[3] = '{1'b0, 32'h600, 32'h0,        32'h00000011, 40, 1'b0, 0, {1'b1, 1'b1, 32'h0, 8'd16}};
    tbl[4] = '{1'b0, 32'h700, 32'h0,        32'h87654321, 2,  1'b0, 5, {1'b0, 1'b0, 32'h87654321, 8'd3}};
    tbl[5] = '{1'b1, 32'h800, 32'h00005A5A, 32'h0000FFFF, 1,  1'b1, 0, {1'b0, 1'b1, 32'h0, 8'd2}};
    tbl[6] = '{1'b0, 32'h900, 32'h0,        32'h00000F0F, 15, 1'b0, 0, {1'b0, 1'b0, 32'h00000F0F, 8'd16}};
    tbl[7] = '{1'b0, 32'hA00, 32'h0,        32'h0000F0F0, 16, 1'b0, 0, {1'b1, 1'b1, 32'h0, 8'd16}};

    // reset state
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", {psel, penable}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout, pwrite}, 0);
    chk("rst_state", dbg_state, 0);
    presetn = 1'b0;
    @(posedge pclk); #1;

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i].exp);
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rd,
              tbl[i].waits, tbl[i].err, tbl[i].hold);
    end

    for (int i = 0; i < 30; i++) begin
      bit wr, err;
      logic [31:0] addr, wdata, rd;
      int waits, hold;
      wr = 1'($urandom); err = 1'($urandom);
      addr = $urandom; wdata = $urandom; rd = $urandom;
      waits = $urandom_range(0, 20); hold = $urandom_range(0, 3);
      exp_q.push_back(model(wr, rd, waits, err));
      run_txn(wr, addr, wdata, rd, waits, err, hold);
    end

    // reset asserted during ACCESS discards the transfer
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h77; cmd_wdata = 32'h0;
    @(posedge pclk); #1;
    cmd_valid = 1'b0; pready = 1'b0;
    @(posedge pclk); #1;
    chk("mid_penable", penable, 1);
    @(posedge pclk); #1;
    presetn = 1'b1; pready = 1'b1; pslverr = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rst_psel", {psel, penable}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_paddr", paddr, 0);
    presetn = 1'b0; pready = 1'b0; pslverr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge pclk); #1;
      chk("post_rst_no_rsp", {rsp_valid, psel}, 0);
    end
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // back-to-back command right after the response handshake
    exp_q.push_back(model(1'b1, 32'h0, 0, 1'b0));
    run_txn(1'b1, 32'h44, 32'h1234, 32'h0, 0, 1'b0, 0);
    exp_q.push_back(model(1'b0, 32'h55AA55AA, 0, 1'b0));
    run_txn(1'b0, 32'h48, 32'h0, 32'h55AA55AA, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
